// File: rtl/adc_sample_sequencer.sv
// AD7673 capture sequencer: paces conversions at the sample interval, runs the
// CNVST_N/BUSY handshake and writes each converted word to sample memory.
module adc_sample_sequencer #(
    parameter int SAMPLE_INTERVAL_CLK = 3000,
    parameter int MEMORY_SIZE         = 441000,
    parameter int CNV_LOW_CLK         = 4,
    parameter int BUSY_TIMEOUT_CLK    = 250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    output logic        recording,
    output logic        done,
    output logic [18:0] write_pointer,
    output logic        mem_we,
    output logic [18:0] mem_addr,
    output logic [9:0]  mem_wdata,
    input  logic        BUSY,
    input  logic [17:0] AD7673_DATA,
    output logic        CNVST_N,
    output logic        overrun,
    output logic        timeout_err
);

    localparam int IW = (SAMPLE_INTERVAL_CLK > 1) ? $clog2(SAMPLE_INTERVAL_CLK) : 1;
    localparam int PW = $clog2(CNV_LOW_CLK + 1);
    localparam int TW = $clog2(BUSY_TIMEOUT_CLK + 1);

    localparam logic [IW-1:0] INT_LAST   = IW'(SAMPLE_INTERVAL_CLK - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CNV_LOW_CLK - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(BUSY_TIMEOUT_CLK - 1);
    localparam logic [18:0]   PTR_FULL   = 19'(MEMORY_SIZE);

    typedef enum logic [2:0] {
        IDLE, WAIT_TICK, CONV, WAIT_HI, WAIT_LO, WRITE
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   int_cnt;
    logic [PW-1:0]   phase;
    logic [TW-1:0]   to_cnt;
    logic            busy_p0, busy_s;
    logic [9:0]      word_p0;
    logic            stop_pending;
    logic            tick;
    logic            start_ok, latch, fill, to_fire;
    logic [18:0]     ptr_inc;
    logic            unused_data_lsb;

    assign unused_data_lsb = ^AD7673_DATA[7:0];

    assign recording = (state != IDLE);
    assign tick      = recording && (int_cnt == INT_LAST);
    assign ptr_inc   = write_pointer + 19'd1;

    assign mem_we    = (state == WRITE);
    assign mem_addr  = mem_we ? write_pointer : '0;
    assign mem_wdata = mem_we ? word_p0 : '0;

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        latch     = 1'b0;
        fill      = 1'b0;
        to_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    start_ok  = 1'b1;
                    state_nxt = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                // A pending stop wins: no conversion has been started yet.
                if (stop_pending)
                    state_nxt = IDLE;
                else if (tick)
                    state_nxt = CONV;
            end
            CONV: begin
                if (phase == PHASE_LAST)
                    state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (busy_s) begin
                    state_nxt = WAIT_LO;
                end else if (to_cnt == TO_LAST) begin
                    to_fire   = 1'b1;
                    state_nxt = WAIT_TICK;
                end
            end
            WAIT_LO: begin
                if (!busy_s) begin
                    latch     = 1'b1;
                    state_nxt = WRITE;
                end else if (to_cnt == TO_LAST) begin
                    to_fire   = 1'b1;
                    state_nxt = WAIT_TICK;
                end
            end
            WRITE: begin
                if (ptr_inc == PTR_FULL) begin
                    fill      = 1'b1;
                    state_nxt = IDLE;
                end else if (stop_pending) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT_TICK;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            CNVST_N       <= 1'b1;
            int_cnt       <= '0;
            phase         <= '0;
            to_cnt        <= '0;
            busy_p0       <= 1'b0;
            busy_s        <= 1'b0;
            write_pointer <= '0;
            done          <= 1'b0;
            overrun       <= 1'b0;
            timeout_err   <= 1'b0;
            stop_pending  <= 1'b0;
        end else begin
            state   <= state_nxt;
            CNVST_N <= (state_nxt != CONV);
            busy_p0 <= BUSY;
            busy_s  <= busy_p0;

            if (start_ok || !recording || int_cnt == INT_LAST)
                int_cnt <= '0;
            else
                int_cnt <= int_cnt + IW'(1);

            phase <= (state == CONV) ? phase + PW'(1) : '0;

            // Restart the BUSY-edge timeout on every state change.
            if (state_nxt != state)
                to_cnt <= '0;
            else if (state == WAIT_HI || state == WAIT_LO)
                to_cnt <= to_cnt + TW'(1);
            else
                to_cnt <= '0;

            if (start_ok)
                write_pointer <= '0;
            else if (state == WRITE)
                write_pointer <= ptr_inc;

            if (start_ok) begin
                done        <= 1'b0;
                overrun     <= 1'b0;
                timeout_err <= 1'b0;
            end else begin
                if (fill)
                    done <= 1'b1;
                if (tick && state != WAIT_TICK)
                    overrun <= 1'b1;
                if (to_fire)
                    timeout_err <= 1'b1;
            end

            if (state_nxt == IDLE)
                stop_pending <= 1'b0;
            else if (stop && recording)
                stop_pending <= 1'b1;
        end
    end

    // Capture stage: converted word, taken only once busy_s has dropped.
    always_ff @(posedge clk) begin
        if (latch)
            word_p0 <= AD7673_DATA[17:8];
    end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Randomized bench for adc_sample_sequencer with an AD7673 BUSY model and a
// session-level reference of the writes, flags and conversion pacing.
module tb_adc_sample_sequencer;

    localparam int SI = 20;
    localparam int MS = 4;
    localparam int CL = 2;
    localparam int BT = 10;

    logic        clk = 1'b0;
    logic        reset, start, stop;
    logic        recording, done, mem_we, CNVST_N, overrun, timeout_err;
    logic [18:0] write_pointer, mem_addr;
    logic [9:0]  mem_wdata;
    logic        BUSY;
    logic [17:0] AD7673_DATA;

    adc_sample_sequencer #(
        .SAMPLE_INTERVAL_CLK(SI), .MEMORY_SIZE(MS),
        .CNV_LOW_CLK(CL), .BUSY_TIMEOUT_CLK(BT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .recording(recording), .done(done), .write_pointer(write_pointer),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .BUSY(BUSY), .AD7673_DATA(AD7673_DATA), .CNVST_N(CNVST_N),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          c;
        logic [18:0] addr;
        logic [9:0]  data;
    } wr_t;

    wr_t         wr_q[$];
    int          fall_q[$];
    int          width_q[$];
    logic [17:0] adc_q[$];
    logic [17:0] words[4];

    int busy_dly   = 3;
    int busy_len   = 5;
    bit busy_never = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Observer: writes, CNVST_N falling edges and low-pulse widths.
    initial begin
        logic prev_cnv;
        int   low_cnt;
        wr_t  w;
        prev_cnv = 1'b1;
        low_cnt  = 0;
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                w.c = cyc; w.addr = mem_addr; w.data = mem_wdata;
                wr_q.push_back(w);
            end
            if (prev_cnv === 1'b1 && CNVST_N === 1'b0)
                fall_q.push_back(cyc);
            if (CNVST_N === 1'b0) begin
                low_cnt++;
            end else if (low_cnt != 0) begin
                width_q.push_back(low_cnt);
                low_cnt = 0;
            end
            prev_cnv = CNVST_N;
        end
    end

    // AD7673 model: BUSY rises busy_dly cycles after CNVST_N falls, holds
    // busy_len cycles, and presents the next queued word as it falls.
    initial begin
        int d, l;
        bit nv;
        BUSY = 1'b0;
        AD7673_DATA = '0;
        forever begin
            @(negedge CNVST_N);
            d = busy_dly; l = busy_len; nv = busy_never;
            if (!nv) begin
                repeat (d) @(posedge clk);
                #1 BUSY = 1'b1;
                repeat (l) @(posedge clk);
                #1;
                if (adc_q.size() > 0)
                    AD7673_DATA = adc_q.pop_front();
                else
                    AD7673_DATA = '0;
                BUSY = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        wr_q.delete();
        fall_q.delete();
        width_q.delete();
    endtask

    task automatic pulse_start(output int s);
        @(posedge clk); #1;
        start = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && recording !== 1'b0; i++) @(negedge clk);
        chk(tag, 32'(recording), 0);
    endtask

    // One session: stop pulsed one cycle after the n-th CNVST_N fall (n>MS: never).
    task automatic run_session(input int n, input bit fixed);
        int s, exp_n;
        exp_n = (n > MS) ? MS : n;
        for (int i = 0; i < 4; i++) words[i] = 18'($urandom);
        if (fixed) begin
            words[0] = 18'h3FF00;
            words[1] = 18'h00100;
        end
        adc_q.delete();
        for (int i = 0; i < 4; i++) adc_q.push_back(words[i]);
        clear_obs();
        pulse_start(s);
        @(negedge clk);
        chk("sess_rec_set",  32'(recording), 1);
        chk("sess_wp_clr",   32'(write_pointer), 0);
        chk("sess_done_clr", 32'(done), 0);
        chk("sess_ovr_clr",  32'(overrun), 0);
        chk("sess_to_clr",   32'(timeout_err), 0);
        if (n <= MS) begin
            for (int i = 0; i < 300 && fall_q.size() < n; i++) @(negedge clk);
            chk("sess_stop_fall", 32'(fall_q.size()), 32'(n));
            pulse_stop();
        end
        wait_idle("sess_end");
        repeat (45) @(negedge clk);
        chk("sess_writes", 32'(wr_q.size()), 32'(exp_n));
        chk("sess_falls",  32'(fall_q.size()), 32'(exp_n));
        chk("sess_wp",     32'(write_pointer), 32'(exp_n));
        chk("sess_done",   32'(done), 32'(exp_n == MS));
        chk("sess_ovr",    32'(overrun), 0);
        chk("sess_to",     32'(timeout_err), 0);
        if (fall_q.size() > 0)
            chk("sess_first_fall", 32'(fall_q[0]), 32'(s + SI + 1));
        for (int i = 0; i < wr_q.size(); i++) begin
            chk("sess_addr", 32'(wr_q[i].addr), 32'(i));
            chk("sess_data", 32'(wr_q[i].data), 32'(words[i][17:8]));
            if (i > 0)
                chk("sess_spacing", 32'(wr_q[i].c - wr_q[i-1].c), SI);
        end
        for (int i = 0; i < width_q.size(); i++)
            chk("sess_cnv_width", 32'(width_q[i]), CL);
    endtask

    initial begin
        int s, f1, f2;
        logic [17:0] w1;
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_cnvst", 32'(CNVST_N), 1);
        chk("rst_rec",   32'(recording), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_wp",    32'(write_pointer), 0);
        chk("rst_we",    32'(mem_we), 0);
        chk("rst_addr",  32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_ovr",   32'(overrun), 0);
        chk("rst_to",    32'(timeout_err), 0);

        // Reset while CNVST_N is low.
        clear_obs();
        pulse_start(s);
        for (int i = 0; i < 60 && CNVST_N !== 1'b0; i++) @(negedge clk);
        chk("rm_in_conv", 32'(CNVST_N), 0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rm_cnvst", 32'(CNVST_N), 1);
        chk("rm_rec",   32'(recording), 0);
        chk("rm_wp",    32'(write_pointer), 0);
        chk("rm_we",    32'(mem_we), 0);
        repeat (40) @(negedge clk);
        chk("rm_no_write", 32'(wr_q.size()), 0);

        // BUSY never rises.
        busy_never = 1'b1;
        adc_q.delete();
        clear_obs();
        pulse_start(s);
        for (int i = 0; i < 60 && fall_q.size() < 1; i++) @(negedge clk);
        chk("to_fall1", 32'(fall_q.size()), 1);
        f1 = (fall_q.size() > 0) ? fall_q[0] : 0;
        for (int i = 0; i < 60 && timeout_err !== 1'b1; i++) @(negedge clk);
        chk("to_flag_cycle", 32'(cyc), 32'(f1 + 12));
        chk("to_no_write", 32'(wr_q.size()), 0);
        chk("to_wp", 32'(write_pointer), 0);
        for (int i = 0; i < 60 && fall_q.size() < 2; i++) @(negedge clk);
        f2 = (fall_q.size() > 1) ? fall_q[1] : 0;
        chk("to_next_fall", 32'(f2 - f1), SI);
        pulse_stop();
        wait_idle("to_end");
        busy_never = 1'b0;
        repeat (20) @(negedge clk);
        chk("to_no_write_end", 32'(wr_q.size()), 0);

        // Slow BUSY: late rise held 25 cycles, so WAIT_LO is still running at the next tick.
        busy_dly = 8; busy_len = 25;
        w1 = 18'($urandom);
        adc_q.delete();
        adc_q.push_back(18'($urandom));
        adc_q.push_back(w1);
        clear_obs();
        pulse_start(s);
        for (int i = 0; i < 60 && fall_q.size() < 1; i++) @(negedge clk);
        @(posedge clk); #1 busy_dly = 3; busy_len = 5;
        for (int i = 0; i < 120 && wr_q.size() < 1; i++) @(negedge clk);
        chk("ov_write_seen", 32'(wr_q.size()), 1);
        chk("ov_overrun", 32'(overrun), 1);
        chk("ov_timeout", 32'(timeout_err), 1);
        f2 = (fall_q.size() > 1) ? fall_q[1] - fall_q[0] : 0;
        chk("ov_fall_gap", 32'(f2), 2 * SI);
        if (wr_q.size() > 0) begin
            chk("ov_addr", 32'(wr_q[0].addr), 0);
            chk("ov_data", 32'(wr_q[0].data), 32'(w1[17:8]));
        end
        pulse_stop();
        wait_idle("ov_end");
        repeat (30) @(negedge clk);
        chk("ov_wp", 32'(write_pointer), 1);
        chk("ov_writes", 32'(wr_q.size()), 1);

        // start and stop together in IDLE: ignored, sticky flags kept.
        @(posedge clk); #1 start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        chk("sc_rec", 32'(recording), 0);
        chk("sc_ovr_kept", 32'(overrun), 1);
        chk("sc_to_kept", 32'(timeout_err), 1);

        run_session(5, 1'b1);
        chk("fill_done_before_restart", 32'(done), 1);
        run_session(2, 1'b0);
        for (int k = 0; k < 3; k++)
            run_session(int'($urandom_range(1, 5)), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
